// File: rtl/dplca_txop_table_pkg.sv
// Shared encodings for the D-PLCA TXOP table: claim codes, ON/OFF, TRUE/FALSE, FSM states.
package dplca_txop_table_pkg;
    localparam logic [1:0] UNCLAIMED = 2'd0;
    localparam logic [1:0] CLAIMED   = 2'd1;
    localparam logic       ON        = 1'b1;
    localparam logic       OFF       = 1'b0;
    localparam logic       TRUE      = 1'b1;
    localparam logic       FALSE     = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;
endpackage

// File: rtl/dplca_age_ram.sv
// 256 x 3-bit age store: single port, synchronous write, registered read.
module dplca_age_ram (
    input  logic       clk,
    input  logic [7:0] addr,
    input  logic       we,
    input  logic [2:0] wdata,
    output logic [2:0] rd_data
);
    logic [2:0] mem [256];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rd_data <= mem[addr];
    end
endmodule

// File: rtl/dplca_txop_table.sv
// D-PLCA TXOP table manager: records claims per TXOP ID, ages idle entries and
// derives the node count for the next PLCA cycle.
module dplca_txop_table
    import dplca_txop_table_pkg::*;
#(
    parameter int AGE_MAX        = 7,
    parameter int WARMUP_CYCLES  = 4,
    parameter int MIN_NODE_COUNT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dplca_en,
    input  logic [7:0] plca_node_count_cfg,
    input  logic [1:0] dplca_txop_claim,
    input  logic       dplca_txop_end,
    input  logic [7:0] dplca_txop_id,
    input  logic       plca_cycle_start,
    output logic       dplca_txop_table_upd,
    output logic       dplca_aging,
    output logic [7:0] plca_node_count
);
    localparam logic [2:0] AGE_LD  = 3'(AGE_MAX);
    localparam logic [7:0] WARM_MX = 8'(WARMUP_CYCLES);
    localparam logic [7:0] MIN_NC  = 8'(MIN_NODE_COUNT);

    state_t     state;
    logic [7:0] clr_idx, id_q, max_active, warm, node_q;
    logic [1:0] claim_q;
    logic       end_q, en_q, any_active, upd_q;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [2:0] ram_wdata, rd_age, new_age;
    logic       clear_mode, wr_active, eff_any;
    logic [7:0] eff_max, sat_cnt, next_node;
    logic [8:0] cnt9;

    dplca_age_ram u_ram (
        .clk    (clk),
        .addr   (ram_addr),
        .we     (ram_we),
        .wdata  (ram_wdata),
        .rd_data(rd_age)
    );

    assign clear_mode  = !dplca_en || (state == ST_CLEAR);
    assign dplca_aging = (dplca_en && state != ST_CLEAR && warm == WARM_MX) ? ON : OFF;

    always_comb begin
        new_age = rd_age;
        if (claim_q == CLAIMED)                   new_age = AGE_LD;
        else if (dplca_aging == ON && rd_age != 0) new_age = rd_age - 3'd1;
    end

    // A write landing in the same clk as cycle start still counts toward that cycle.
    assign wr_active = (state == ST_WRITE) && (new_age != 3'd0);
    assign eff_any   = any_active || wr_active;
    assign eff_max   = wr_active ? id_q : max_active;
    assign cnt9      = eff_any ? ({1'b0, eff_max} + 9'd1) : 9'd0;
    assign sat_cnt   = cnt9[8] ? 8'hff : cnt9[7:0];
    assign next_node = (sat_cnt < MIN_NC) ? MIN_NC : sat_cnt;

    always_comb begin
        ram_addr  = id_q;
        ram_we    = FALSE;
        ram_wdata = new_age;
        if (state == ST_CLEAR) begin
            ram_addr  = clr_idx;
            ram_we    = TRUE;
            ram_wdata = 3'd0;
        end else if (state == ST_WRITE) begin
            ram_we = TRUE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_idx <= 8'd0;
            id_q    <= 8'd0;
            claim_q <= UNCLAIMED;
            end_q   <= 1'b0;
            en_q    <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            end_q <= dplca_txop_end;
            en_q  <= dplca_en;
            if (en_q && !dplca_en) begin
                state   <= ST_CLEAR;
                clr_idx <= 8'd0;
                upd_q   <= 1'b0;
            end else begin
                case (state)
                    ST_CLEAR: begin
                        clr_idx <= clr_idx + 8'd1;
                        if (clr_idx == 8'hff) state <= ST_IDLE;
                    end
                    ST_IDLE: if (dplca_en && dplca_txop_end && !end_q) begin
                        id_q    <= dplca_txop_id;
                        claim_q <= dplca_txop_claim;
                        state   <= ST_LOOKUP;
                    end
                    ST_LOOKUP: state <= ST_WRITE;
                    ST_WRITE: begin
                        state <= ST_DONE;
                        upd_q <= 1'b1;
                    end
                    ST_DONE: if (!dplca_txop_end) begin
                        state <= ST_IDLE;
                        upd_q <= 1'b0;
                    end
                    default: state <= ST_CLEAR;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_mode) begin
            max_active <= 8'd0;
            any_active <= 1'b0;
            warm       <= 8'd0;
            node_q     <= plca_node_count_cfg;
        end else if (plca_cycle_start) begin
            node_q     <= next_node;
            max_active <= 8'd0;
            any_active <= 1'b0;
            if (warm != WARM_MX) warm <= warm + 8'd1;
        end else if (wr_active) begin
            max_active <= id_q;
            any_active <= 1'b1;
        end
    end

    assign dplca_txop_table_upd = upd_q;
    assign plca_node_count      = clear_mode ? plca_node_count_cfg : node_q;
endmodule

// File: tb/tb_dplca_txop_table.sv
// Directed bench for dplca_txop_table: reset sweep, claims, aging, empty table,
// ID 255 saturation, cycle-start/WRITE coincidence and disable during DONE.
module tb_dplca_txop_table;
    import dplca_txop_table_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dplca_en = 1'b1;
    logic [7:0] plca_node_count_cfg = 8'd8;
    logic [1:0] dplca_txop_claim = UNCLAIMED;
    logic       dplca_txop_end = 1'b0;
    logic [7:0] dplca_txop_id = 8'd0;
    logic       plca_cycle_start = 1'b0;
    logic       dplca_txop_table_upd, dplca_aging;
    logic [7:0] plca_node_count;

    int checks = 0;
    int failures = 0;

    dplca_txop_table dut (
        .clk                 (clk),
        .reset               (reset),
        .dplca_en            (dplca_en),
        .plca_node_count_cfg (plca_node_count_cfg),
        .dplca_txop_claim    (dplca_txop_claim),
        .dplca_txop_end      (dplca_txop_end),
        .dplca_txop_id       (dplca_txop_id),
        .plca_cycle_start    (plca_cycle_start),
        .dplca_txop_table_upd(dplca_txop_table_upd),
        .dplca_aging         (dplca_aging),
        .plca_node_count     (plca_node_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Full TXOP handshake: upd must appear exactly three clks after the end rise.
    task automatic txop(input logic [7:0] id, input logic [1:0] claim);
        dplca_txop_id    = id;
        dplca_txop_claim = claim;
        dplca_txop_end   = 1'b1;
        tick(); chk("upd_n1", 32'(dplca_txop_table_upd), 0);
        tick(); chk("upd_n2", 32'(dplca_txop_table_upd), 0);
        tick(); chk("upd_n3", 32'(dplca_txop_table_upd), 1);
        tick(); chk("upd_hold", 32'(dplca_txop_table_upd), 1);
        dplca_txop_end = 1'b0;
        tick(); chk("upd_fall", 32'(dplca_txop_table_upd), 0);
    endtask

    task automatic cycle(input string tag, input logic [7:0] exp_nc, input logic exp_aging);
        plca_cycle_start = 1'b1;
        tick();
        plca_cycle_start = 1'b0;
        chk(tag, 32'(plca_node_count), 32'(exp_nc));
        chk("aging", 32'(dplca_aging), 32'(exp_aging));
    endtask

    initial begin
        tick();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            chk("rst_state", 32'(dut.state), 32'(ST_CLEAR));
            chk("rst_upd", 32'(dplca_txop_table_upd), 0);
            chk("rst_aging", 32'(dplca_aging), 0);
            chk("rst_nc", 32'(plca_node_count), 8);
            tick();
        end
        chk("idle_after_sweep", 32'(dut.state), 32'(ST_IDLE));
        chk("idle_nc", 32'(plca_node_count), 8);

        txop(8'd3, CLAIMED);
        txop(8'd5, CLAIMED);
        cycle("claims_nc", 8'd6, 1'b0);

        // ID 5 stops claiming; aging turns on after the fourth cycle start.
        for (int c = 2; c <= 12; c++) begin
            txop(8'd3, CLAIMED);
            txop(8'd5, UNCLAIMED);
            cycle((c <= 10) ? "aging_nc_active" : "aging_nc_expired",
                  (c <= 10) ? 8'd6 : 8'd4, (c >= 4));
        end

        cycle("empty_nc", 8'd2, 1'b1);
        txop(8'd255, CLAIMED);
        cycle("id255_nc", 8'd255, 1'b1);

        dplca_txop_id    = 8'd9;
        dplca_txop_claim = CLAIMED;
        dplca_txop_end   = 1'b1;
        tick();
        tick();
        chk("coin_in_write", 32'(dut.state), 32'(ST_WRITE));
        plca_cycle_start = 1'b1;
        tick();
        plca_cycle_start = 1'b0;
        chk("coin_upd", 32'(dplca_txop_table_upd), 1);
        chk("coin_nc", 32'(plca_node_count), 10);
        dplca_txop_end = 1'b0;
        tick();
        cycle("after_coin_nc", 8'd2, 1'b1);

        plca_node_count_cfg = 8'd20;
        dplca_txop_id    = 8'd7;
        dplca_txop_claim = CLAIMED;
        dplca_txop_end   = 1'b1;
        tick(); tick(); tick();
        chk("dis_done_upd", 32'(dplca_txop_table_upd), 1);
        dplca_en = 1'b0;
        tick();
        chk("dis_upd", 32'(dplca_txop_table_upd), 0);
        chk("dis_nc", 32'(plca_node_count), 20);
        chk("dis_aging", 32'(dplca_aging), 0);
        chk("dis_state", 32'(dut.state), 32'(ST_CLEAR));
        dplca_txop_end = 1'b0;
        for (int i = 0; i < 256; i++) tick();
        chk("dis_sweep_done", 32'(dut.state), 32'(ST_IDLE));
        chk("dis_nc_idle", 32'(plca_node_count), 20);
        dplca_en = 1'b1;
        tick();
        chk("reen_nc", 32'(plca_node_count), 20);
        chk("reen_aging", 32'(dplca_aging), 0);
        txop(8'd3, UNCLAIMED);
        txop(8'd7, UNCLAIMED);
        cycle("swept_nc", 8'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
